// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear sequencer and debug tap.
// Optional write-through bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned TAP_REG    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] AD,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD,
    input  logic [ADDR_WIDTH-1:0]        AD3,
    input  logic                         WE3,
    input  logic [DATA_WIDTH-1:0]        WD3,
    output logic                         busy,
    output logic                         wr_drop,
    output logic [DATA_WIDTH-1:0]        tap_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] TAP_ADDR = ADDR_WIDTH'(TAP_REG);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    wr_drop_q, wr_drop_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    logic                    usr_wr_c;
    logic                    drop_req_c;
    logic                    wr_en_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;

    assign busy    = (state_q == ST_CLEAR);
    assign wr_drop = wr_drop_q;

    // A user write is honoured only in READY outside the reset cycle; writes to x0 are no-ops.
    assign usr_wr_c   = (state_q == ST_READY) && !rst && WE3 && (AD3 != '0);
    assign drop_req_c = WE3 && (AD3 != '0) && (busy || rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            wr_drop_q <= drop_req_c;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_drop_d = wr_drop_q | drop_req_c;
        wr_en_c   = 1'b0;
        wr_addr_c = clr_cnt_q;
        wr_data_c = '0;
        if (!rst) begin
            case (state_q)
                ST_CLEAR: begin
                    wr_en_c = 1'b1;
                    // Counter holds at the last index; leaving the state ends the sweep.
                    if (clr_cnt_q == LAST_IDX) begin
                        state_d = ST_READY;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (usr_wr_c) begin
                        wr_en_c   = 1'b1;
                        wr_addr_c = AD3;
                        wr_data_c = WD3;
                    end
                end
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    // Storage array; contents are undefined until the clear sweep completes.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            regs_q[wr_addr_c] <= wr_data_c;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_c;
        logic [DATA_WIDTH-1:0] rd_c;

        assign ra_c = AD[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_c = '0;
            if (!busy && (ra_c != '0)) begin
                rd_c = regs_q[ra_c];
`ifdef REGFILE_BYPASS_EN
                if (usr_wr_c && (ra_c == AD3)) begin
                    rd_c = WD3;
                end
`endif
            end
        end

        assign RD[i*DATA_WIDTH +: DATA_WIDTH] = rd_c;
    end

    if (TAP_REG == 0) begin : g_tap_zero
        assign tap_o = '0;
    end else begin : g_tap
        always_comb begin
            tap_o = '0;
            if (!busy) begin
                tap_o = regs_q[TAP_ADDR];
`ifdef REGFILE_BYPASS_EN
                if (usr_wr_c && (AD3 == TAP_ADDR)) begin
                    tap_o = WD3;
                end
`endif
            end
        end
    end

endmodule
